// File: rtl/spi_master_regbus.sv
// spi_master_regbus: SPI mode-0 master issuing single 40-bit register frames
// ({rw, addr[6:0]} command byte followed by 32 data bits, MSB first).
// Optional build macro SPI_MASTER_SAMPLE_LATE_EN moves MISO sampling from the
// SCLK rising edge to the SCLK falling edge (end of the high phase).
module spi_master_regbus #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  addr,
  input  logic [31:0] wdat,
  output logic [31:0] rdat,
  output logic        busy,
  output logic        done,
  output logic        spi_csl,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [6:0] BIT_LAST   = 7'd79;
  localparam logic [6:0] BIT_FALL40 = 7'd78;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_div;
  logic [6:0]  r_bit;
  logic        r_sclk;
  logic        r_csl;
  logic        r_mosi;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_rdat;
  logic [38:0] r_sh;
  logic [31:0] r_cap;
  logic        r_rw;

  logic        w_div_end;
  logic        w_accept;
  logic        w_rise;
  logic        w_fall;
  logic        w_sample;
  logic [39:0] w_frame;

`ifdef SPI_MASTER_SAMPLE_LATE_EN
  assign w_sample = w_fall;
`else
  assign w_sample = w_rise;
`endif

  // Next-state decode plus the SCLK edge strobes for this cycle.
  always_comb begin
    w_next    = r_state;
    w_div_end = (r_div == DIV_LAST);
    w_accept  = 1'b0;
    w_rise    = 1'b0;
    w_fall    = 1'b0;
    w_frame   = {rw, addr, (rw ? 32'd0 : wdat)};
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = SETUP;
        end
      end
      SETUP: begin
        if (w_div_end) begin
          w_rise = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        // Half-period index r_bit: even = SCLK high, odd = SCLK low.
        if (w_div_end) begin
          if (r_bit == BIT_LAST) w_next = HOLD;
          else if (r_bit[0])     w_rise = 1'b1;
          else                   w_fall = 1'b1;
        end
      end
      HOLD: begin
        if (w_div_end) w_next = GAP;
      end
      GAP: begin
        if (w_div_end) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Control outputs, counters and read-data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= 8'd0;
      r_bit  <= 7'd0;
      r_sclk <= 1'b0;
      r_csl  <= 1'b1;
      r_mosi <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rdat <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE || w_div_end) r_div <= 8'd0;
      else                              r_div <= r_div + 8'd1;
      if (w_accept) begin
        r_busy <= 1'b1;
        r_csl  <= 1'b0;
        r_mosi <= w_frame[39];
        r_bit  <= 7'd0;
      end
      if (w_rise) r_sclk <= 1'b1;
      if (w_fall) begin
        r_sclk <= 1'b0;
        r_mosi <= (r_bit == BIT_FALL40) ? 1'b0 : r_sh[38];
      end
      if (r_state == SHIFT && w_div_end)
        r_bit <= (r_bit == BIT_LAST) ? 7'd0 : r_bit + 7'd1;
      // CSL releases after the first GAP cycle so that, counting the done
      // cycle, a back-to-back frame sees exactly CLK_DIV cycles of CSL high.
      if (r_state == GAP) begin
        r_csl <= 1'b1;
        if (w_div_end) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_rw) r_rdat <= r_cap;
        end
      end
    end
  end

  // Frame shift register (bits below the one on MOSI) and MISO capture.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sh <= w_frame[38:0];
      r_rw <= rw;
    end else if (w_fall) begin
      r_sh <= {r_sh[37:0], 1'b0};
    end
    if (w_sample) r_cap <= {r_cap[30:0], spi_miso};
  end

  assign rdat     = r_rdat;
  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_csl  = r_csl;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_master_regbus.sv
// Directed bench for spi_master_regbus: one instance at CLK_DIV=4 and one at
// CLK_DIV=1, each with a behavioural register-port slave on the SPI pins.
module tb_spi_master_regbus;

`ifdef SPI_MASTER_SAMPLE_LATE_EN
  localparam bit LATE = 1'b1;
`else
  localparam bit LATE = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic        a_start = 1'b0, a_rw = 1'b0;
  logic [6:0]  a_addr  = 7'd0;
  logic [31:0] a_wdat  = 32'd0;
  logic [31:0] a_rdat;
  logic        a_busy, a_done, a_csl, a_sclk, a_mosi, a_miso;

  logic        b_start = 1'b0, b_rw = 1'b0;
  logic [6:0]  b_addr  = 7'd0;
  logic [31:0] b_wdat  = 32'd0;
  logic [31:0] b_rdat;
  logic        b_busy, b_done, b_csl, b_sclk, b_mosi, b_miso;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master_regbus #(.CLK_DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .rw(a_rw), .addr(a_addr),
    .wdat(a_wdat), .rdat(a_rdat), .busy(a_busy), .done(a_done),
    .spi_csl(a_csl), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso)
  );

  spi_master_regbus #(.CLK_DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .rw(b_rw), .addr(b_addr),
    .wdat(b_wdat), .rdat(b_rdat), .busy(b_busy), .done(b_done),
    .spi_csl(b_csl), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso)
  );

  // Slave model A: response frame {8'h00, sa_rdata}, records completed writes.
  logic [39:0] sa_rx = '0, sa_tx = '0;
  logic [31:0] sa_rdata = '0, sa_wdat = '0;
  logic [6:0]  sa_waddr = '0;
  int          sa_nrise = 0, sa_frames = 0, sa_wcount = 0;
  logic        pa_csl = 1'b1, pa_sclk = 1'b0;
  assign a_miso = sa_tx[39];
  always @(a_csl or a_sclk) begin
    if (pa_csl !== 1'b0 && a_csl === 1'b0) begin
      sa_tx = {8'h00, sa_rdata}; sa_nrise = 0; sa_frames++;
    end else if (pa_csl === 1'b0 && a_csl !== 1'b0) begin
      if (sa_nrise == 40 && sa_rx[39] == 1'b0) begin
        sa_wcount++; sa_waddr = sa_rx[38:32]; sa_wdat = sa_rx[31:0];
      end
    end else if (a_csl === 1'b0 && pa_sclk === 1'b0 && a_sclk === 1'b1) begin
      sa_rx = {sa_rx[38:0], a_mosi}; sa_nrise++;
    end else if (a_csl === 1'b0 && pa_sclk === 1'b1 && a_sclk === 1'b0) begin
      sa_tx = {sa_tx[38:0], 1'b0};
    end
    pa_csl = a_csl; pa_sclk = a_sclk;
  end

  // Slave model B; in late-sample builds its MISO reaches the master 1 clk late.
  logic [39:0] sb_rx = '0, sb_tx = '0;
  logic [31:0] sb_rdata = '0;
  int          sb_nrise = 0;
  logic        pb_csl = 1'b1, pb_sclk = 1'b0, sb_dly = 1'b0;
  always @(posedge clk) sb_dly <= sb_tx[39];
  assign b_miso = LATE ? sb_dly : sb_tx[39];
  always @(b_csl or b_sclk) begin
    if (pb_csl !== 1'b0 && b_csl === 1'b0) begin
      sb_tx = {8'h00, sb_rdata}; sb_nrise = 0;
    end else if (b_csl === 1'b0 && pb_sclk === 1'b0 && b_sclk === 1'b1) begin
      sb_rx = {sb_rx[38:0], b_mosi}; sb_nrise++;
    end else if (b_csl === 1'b0 && pb_sclk === 1'b1 && b_sclk === 1'b0) begin
      sb_tx = {sb_tx[38:0], 1'b0};
    end
    pb_csl = b_csl; pb_sclk = b_sclk;
  end

  // done-pulse counter and CSL-high run length for instance A.
  int a_done_cnt = 0, hi_run = 0, last_hi = 0;
  always @(posedge clk) begin
    if (a_done === 1'b1) a_done_cnt <= a_done_cnt + 1;
    if (a_csl === 1'b1) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_hi <= hi_run;
      hi_run <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one frame on A and return in its done cycle (bounded).
  task automatic run_a(input logic r, input logic [6:0] ad, input logic [31:0] wd,
                       output int busy_cyc, output bit got_done);
    a_rw = r; a_addr = ad; a_wdat = wd; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    busy_cyc = 0; got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      if (a_done === 1'b1) got_done = 1'b1;
      else begin
        if (a_busy === 1'b1) busy_cyc++;
        tick();
      end
    end
  endtask

  // Launch one read on B, counting busy cycles and SCLK toggles.
  task automatic run_b(input logic [6:0] ad, output int busy_cyc, output int toggles,
                       output bit got_done);
    logic prev;
    b_rw = 1'b1; b_addr = ad; b_wdat = 32'd0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    busy_cyc = 0; toggles = 0; got_done = 1'b0; prev = 1'b0;
    for (int i = 0; i < 500 && !got_done; i++) begin
      if (b_done === 1'b1) got_done = 1'b1;
      else begin
        if (b_busy === 1'b1) busy_cyc++;
        if (b_sclk !== prev) toggles++;
        prev = b_sclk;
        tick();
      end
    end
  endtask

  initial begin
    int bc, tg, w0, f0, d0;
    bit gd;

    // Reset state
    tick(); tick();
    chk("rst_csl",  64'(a_csl),  64'd1);
    chk("rst_sclk", 64'(a_sclk), 64'd0);
    chk("rst_mosi", 64'(a_mosi), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_rdat", 64'(a_rdat), 64'd0);
    reset = 1'b0;
    tick();

    // Read DESIGN_ID
    sa_rdata = 32'h1CE50100;
    w0 = sa_wcount;
    run_a(1'b1, 7'h00, 32'h0, bc, gd);
    chk("rd_done",      64'(gd),     64'd1);
    chk("rd_busy_len",  64'(bc),     64'd332);
    chk("rd_busy_done", 64'(a_busy), 64'd0);
    chk("rd_rdat",      64'(a_rdat), 64'h1CE50100);
    chk("rd_mosi",      64'(sa_rx),  64'h80_0000_0000);
    chk("rd_nrise",     64'(sa_nrise), 64'd40);
    chk("rd_no_write",  64'(sa_wcount - w0), 64'd0);
    tick();
    chk("rd_done_pulse", 64'(a_done), 64'd0);
    chk("rd_csl_idle",   64'(a_csl),  64'd1);

    // Write blink limit
    w0 = sa_wcount;
    run_a(1'b0, 7'h01, 32'h000009C3, bc, gd);
    chk("wr_done",     64'(gd),     64'd1);
    chk("wr_busy_len", 64'(bc),     64'd332);
    chk("wr_mosi",     64'(sa_rx),  64'h01_0000_09C3);
    chk("wr_we",       64'(sa_wcount - w0), 64'd1);
    chk("wr_addr",     64'(sa_waddr), 64'h01);
    chk("wr_data",     64'(sa_wdat),  64'h9C3);
    chk("wr_rdat_keep", 64'(a_rdat), 64'h1CE50100);
    tick();

    // Start while busy is ignored
    sa_rdata = 32'h12345678;
    f0 = sa_frames; d0 = a_done_cnt;
    a_rw = 1'b1; a_addr = 7'h00; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (98) tick();
    a_addr = 7'h7F; a_start = 1'b1;
    tick();
    a_start = 1'b0; a_addr = 7'h00;
    gd = 1'b0;
    for (int i = 0; i < 400 && !gd; i++) begin
      if (a_done === 1'b1) gd = 1'b1;
      else tick();
    end
    chk("busy_done",   64'(gd),     64'd1);
    chk("busy_rdat",   64'(a_rdat), 64'h12345678);
    chk("busy_mosi",   64'(sa_rx),  64'h80_0000_0000);
    repeat (20) tick();
    chk("busy_frames", 64'(sa_frames - f0),  64'd1);
    chk("busy_dones",  64'(a_done_cnt - d0), 64'd1);

    // Back-to-back: second start issued in the done cycle
    sa_rdata = 32'hCAFEF00D;
    w0 = sa_wcount;
    run_a(1'b1, 7'h00, 32'h0, bc, gd);
    chk("b2b_rd_done", 64'(gd),     64'd1);
    chk("b2b_rd_rdat", 64'(a_rdat), 64'hCAFEF00D);
    run_a(1'b0, 7'h01, 32'h000055AA, bc, gd);
    chk("b2b_wr_done", 64'(gd),       64'd1);
    chk("b2b_wr_busy", 64'(bc),       64'd332);
    chk("b2b_wr_data", 64'(sa_wdat),  64'h55AA);
    chk("b2b_wr_we",   64'(sa_wcount - w0), 64'd1);
    chk("b2b_csl_hi",  64'(last_hi),  64'd4);
    chk("b2b_rdat_keep", 64'(a_rdat), 64'hCAFEF00D);
    tick();

    // Reset mid-frame after the 20th rising SCLK edge
    sa_rdata = 32'h000009C3;
    a_rw = 1'b1; a_addr = 7'h01; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < 1000 && sa_nrise < 20; i++) tick();
    chk("mid_nrise", 64'(sa_nrise), 64'd20);
    d0 = a_done_cnt;
    reset = 1'b1;
    tick();
    chk("mid_csl",  64'(a_csl),  64'd1);
    chk("mid_sclk", 64'(a_sclk), 64'd0);
    chk("mid_busy", 64'(a_busy), 64'd0);
    chk("mid_rdat", 64'(a_rdat), 64'd0);
    chk("mid_mosi", 64'(a_mosi), 64'd0);
    reset = 1'b0;
    repeat (40) tick();
    chk("mid_no_done", 64'(a_done_cnt - d0), 64'd0);
    run_a(1'b1, 7'h01, 32'h0, bc, gd);
    chk("mid_rd_done", 64'(gd),     64'd1);
    chk("mid_rd_rdat", 64'(a_rdat), 64'h000009C3);
    chk("mid_rd_mosi", 64'(sa_rx),  64'h81_0000_0000);
    tick();

    // CLK_DIV=1 boundary on instance B
    sb_rdata = 32'hA5A5A5A5;
    run_b(7'h01, bc, tg, gd);
    chk("div1_done",    64'(gd),       64'd1);
    chk("div1_busy",    64'(bc),       64'd83);
    chk("div1_toggles", 64'(tg),       64'd80);
    chk("div1_rdat",    64'(b_rdat),   64'hA5A5A5A5);
    chk("div1_nrise",   64'(sb_nrise), 64'd40);
    chk("div1_mosi",    64'(sb_rx),    64'h81_0000_0000);
    tick();
    chk("div1_done_pulse", 64'(b_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
